// File: rtl/sparse_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sparse_ctrl_pkg
// Definitions shared by the sparse pair sequencer and its helpers:
//   - state_t        : sequencer FSM state encoding
//   - ORDER_*        : loop-order select values for the 'order' input
//   - FLAG_*         : bit positions of the per-pair qualifier bundle
//   - clamp_count()  : limit a nonzero count to the buffer depth
// ---------------------------------------------------------------------------
package sparse_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // order = 0: weight index is the outer loop, activation index the inner loop
  localparam logic ORDER_W_OUTER = 1'b0;
  // order = 1: activation index is the outer loop, weight index the inner loop
  localparam logic ORDER_A_OUTER = 1'b1;

  // Bit positions inside the 3-bit qualifier bundle carried by the delay line
  localparam int FLAG_VALID = 0;
  localparam int FLAG_FIRST = 1;
  localparam int FLAG_LAST  = 2;
  localparam int FLAG_W     = 3;

  // A buffer holds 2^addr_w entries, so a count larger than that cannot be
  // addressed; such counts are treated as a full buffer. The caller truncates
  // the result to addr_w+1 bits, which always holds 0..2^addr_w.
  function automatic logic [31:0] clamp_count(input logic [31:0] count,
                                              input int          addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    return (count > depth) ? depth : count;
  endfunction

endpackage

// File: rtl/sparse_flag_delay.sv
// ---------------------------------------------------------------------------
// sparse_flag_delay
// Fixed-latency delay line for the per-pair qualifiers (valid, first, last).
// It realigns the issue-cycle flags with the data returned by the buffers
// RD_LAT cycles later. The line never stalls: downstream backpressure only
// gates issue, so anything already in flight always comes out on time.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset, clears every stage
//   flags_in   in   [FLAG_W] qualifiers sampled in the issue cycle
//   flags_out  out  [FLAG_W] the same qualifiers, RD_LAT cycles later
// ---------------------------------------------------------------------------
module sparse_flag_delay
  import sparse_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [FLAG_W-1:0] flags_out
);

  logic [FLAG_W-1:0] stage_reg [RD_LAT];

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) begin
            stage_reg[gi] <= '0;
          end else begin
            stage_reg[gi] <= flags_in;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (reset) begin
            stage_reg[gi] <= '0;
          end else begin
            stage_reg[gi] <= stage_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign flags_out = stage_reg[RD_LAT-1];

endmodule

// File: rtl/sparse_pair_sequencer.sv
// ---------------------------------------------------------------------------
// sparse_pair_sequencer
// Walks the cartesian product of nonzero activation indices x nonzero weight
// indices after a start, issuing one activation/weight buffer read pair per
// cycle while the MAC array is ready. The pair qualifiers are delayed by the
// buffer read latency so they line up with returned data. A one-cycle done
// pulse closes every accepted job, including empty ones.
//
// Parameters:
//   ADDR_W  buffer address width (buffer depth = 2^ADDR_W)
//   CNT_W   width of the nonzero-count inputs
//   RD_LAT  buffer read latency in cycles (>= 1)
//
// Ports:
//   clk              in   clock
//   reset            in   synchronous active-high reset (aborts any job)
//   start            in   job request, accepted only when idle
//   order            in   0 = weight outer / act inner, 1 = act outer / weight inner
//   act_nz_count     in   [CNT_W] activation nonzero count
//   weight_nz_count  in   [CNT_W] weight nonzero count
//   ready            in   MAC array accepts a pair this cycle
//   act_rd_en        out  activation buffer read strobe
//   act_addr         out  [ADDR_W] activation buffer address
//   wgt_rd_en        out  weight buffer read strobe
//   wgt_addr         out  [ADDR_W] weight buffer address
//   pair_valid       out  buffer data for one pair is valid
//   pair_first       out  first inner element of an outer index
//   pair_last        out  final pair of the job
//   busy             out  sequencer not idle
//   done             out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module sparse_pair_sequencer
  import sparse_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              order,
  input  logic [CNT_W-1:0]  act_nz_count,
  input  logic [CNT_W-1:0]  weight_nz_count,
  input  logic              ready,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_addr,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic              pair_valid,
  output logic              pair_first,
  output logic              pair_last,
  output logic              busy,
  output logic              done
);

  // Lengths need one extra bit so that a full buffer (2^ADDR_W) is representable.
  localparam int IDX_W   = ADDR_W + 1;
  localparam int DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t              state_reg, state_next;
  logic                order_reg;
  logic [IDX_W-1:0]    inner_len_reg, outer_len_reg;
  logic [ADDR_W-1:0]   inner_idx_reg, outer_idx_reg;
  logic [ADDR_W-1:0]   act_hold_reg, wgt_hold_reg;
  logic [DRAIN_W-1:0]  drain_cnt_reg;

  logic [IDX_W-1:0]    act_len, wgt_len;
  logic                start_ok, zero_job;
  logic                issue, inner_at_end, outer_at_end, final_issue, drain_end;
  logic                inner_rd, outer_rd;
  logic                act_issue_rd, wgt_issue_rd;
  logic [ADDR_W-1:0]   act_issue_addr, wgt_issue_addr;
  logic [FLAG_W-1:0]   flags_issue, flags_delayed;

  // -------------------------------------------------------------------------
  // Job qualification and issue conditions
  // -------------------------------------------------------------------------
  assign act_len  = IDX_W'(clamp_count(32'(act_nz_count), ADDR_W));
  assign wgt_len  = IDX_W'(clamp_count(32'(weight_nz_count), ADDR_W));
  assign start_ok = start && (state_reg == ST_IDLE);
  assign zero_job = (act_len == '0) || (wgt_len == '0);

  assign issue        = (state_reg == ST_RUN) && ready;
  assign inner_at_end = ({1'b0, inner_idx_reg} == (inner_len_reg - IDX_W'(1)));
  assign outer_at_end = ({1'b0, outer_idx_reg} == (outer_len_reg - IDX_W'(1)));
  assign final_issue  = issue && inner_at_end && outer_at_end;
  assign drain_end    = (drain_cnt_reg == DRAIN_W'(RD_LAT - 1));

  // The inner operand is re-read every pair; the outer operand only when a new
  // outer index begins, since the MAC keeps it between those reads.
  assign inner_rd = issue;
  assign outer_rd = issue && (inner_idx_reg == '0);

  // Map inner/outer onto the two buffers according to the latched loop order.
  always_comb begin
    if (order_reg == ORDER_W_OUTER) begin
      act_issue_addr = inner_idx_reg;
      wgt_issue_addr = outer_idx_reg;
      act_issue_rd   = inner_rd;
      wgt_issue_rd   = outer_rd;
    end else begin
      act_issue_addr = outer_idx_reg;
      wgt_issue_addr = inner_idx_reg;
      act_issue_rd   = outer_rd;
      wgt_issue_rd   = inner_rd;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = zero_job ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (final_issue) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_end) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Job datapath: latched configuration, loop indices, held addresses and
  // the drain counter.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      order_reg     <= ORDER_W_OUTER;
      inner_len_reg <= '0;
      outer_len_reg <= '0;
      inner_idx_reg <= '0;
      outer_idx_reg <= '0;
      act_hold_reg  <= '0;
      wgt_hold_reg  <= '0;
      drain_cnt_reg <= '0;
    end else begin
      if (start_ok) begin
        order_reg     <= order;
        inner_len_reg <= (order == ORDER_W_OUTER) ? act_len : wgt_len;
        outer_len_reg <= (order == ORDER_W_OUTER) ? wgt_len : act_len;
        inner_idx_reg <= '0;
        outer_idx_reg <= '0;
        act_hold_reg  <= '0;
        wgt_hold_reg  <= '0;
      end

      // The final issue leaves the indices alone so the drain phase keeps
      // presenting the last pair's addresses.
      if (issue) begin
        act_hold_reg <= act_issue_addr;
        wgt_hold_reg <= wgt_issue_addr;
        if (!final_issue) begin
          if (inner_at_end) begin
            inner_idx_reg <= '0;
            outer_idx_reg <= outer_idx_reg + ADDR_W'(1);
          end else begin
            inner_idx_reg <= inner_idx_reg + ADDR_W'(1);
          end
        end
      end

      if (state_reg == ST_DRAIN) begin
        drain_cnt_reg <= drain_cnt_reg + DRAIN_W'(1);
      end else begin
        drain_cnt_reg <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output logic
  // During a stall the addresses show the last issued pair rather than the
  // pending one, so the buffer address bus only moves on real reads.
  // -------------------------------------------------------------------------
  always_comb begin
    act_rd_en = 1'b0;
    wgt_rd_en = 1'b0;
    act_addr  = '0;
    wgt_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      ST_RUN: begin
        busy      = 1'b1;
        act_rd_en = act_issue_rd;
        wgt_rd_en = wgt_issue_rd;
        act_addr  = issue ? act_issue_addr : act_hold_reg;
        wgt_addr  = issue ? wgt_issue_addr : wgt_hold_reg;
      end
      ST_DRAIN: begin
        busy     = 1'b1;
        act_addr = act_hold_reg;
        wgt_addr = wgt_hold_reg;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Pair qualifiers, realigned to the buffer read latency
  // -------------------------------------------------------------------------
  always_comb begin
    flags_issue             = '0;
    flags_issue[FLAG_VALID] = issue;
    flags_issue[FLAG_FIRST] = outer_rd;
    flags_issue[FLAG_LAST]  = final_issue;
  end

  sparse_flag_delay #(
    .RD_LAT (RD_LAT)
  ) u_flag_delay (
    .clk       (clk),
    .reset     (reset),
    .flags_in  (flags_issue),
    .flags_out (flags_delayed)
  );

  assign pair_valid = flags_delayed[FLAG_VALID];
  assign pair_first = flags_delayed[FLAG_FIRST];
  assign pair_last  = flags_delayed[FLAG_LAST];

endmodule

// File: tb/tb_sparse_pair_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sparse_pair_sequencer
// Scoreboard bench: the stimulus process derives every expected read, stall
// address, pair qualifier and done cycle from the job parameters and the
// ready pattern it drives, and queues them. An independent monitor pops and
// compares whenever the DUT presents a read strobe, a stall cycle, a pair or
// a done pulse.
// ---------------------------------------------------------------------------
module tb_sparse_pair_sequencer;

  localparam int ADDR_W = 6;
  localparam int CNT_W  = 8;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              order;
  logic [CNT_W-1:0]  act_nz_count;
  logic [CNT_W-1:0]  weight_nz_count;
  logic              ready;
  logic              act_rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic              wgt_rd_en;
  logic [ADDR_W-1:0] wgt_addr;
  logic              pair_valid;
  logic              pair_first;
  logic              pair_last;
  logic              busy;
  logic              done;

  sparse_pair_sequencer #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .order           (order),
    .act_nz_count    (act_nz_count),
    .weight_nz_count (weight_nz_count),
    .ready           (ready),
    .act_rd_en       (act_rd_en),
    .act_addr        (act_addr),
    .wgt_rd_en       (wgt_rd_en),
    .wgt_addr        (wgt_addr),
    .pair_valid      (pair_valid),
    .pair_first      (pair_first),
    .pair_last       (pair_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int act_rd; int wgt_rd; int act_a; int wgt_a; } iss_t;
  typedef struct { int cyc; int first; int last; } pair_t;
  typedef struct { int cyc; int act_a; int wgt_a; } stall_t;

  iss_t   iss_q[$];
  pair_t  pair_q[$];
  stall_t stall_q[$];
  int     done_q[$];

  iss_t   ie;
  pair_t  pe;
  stall_t se;
  int     de;

  int vectors = 0;
  int errors  = 0;
  bit mon_en  = 1'b0;
  int job_no  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (act_rd_en || wgt_rd_en) begin
        if (iss_q.size() == 0) begin
          chk("spurious_read", 1, 0);
        end else begin
          ie = iss_q.pop_front();
          chk("issue_cycle", cyc, ie.cyc);
          chk("act_rd_en", int'(act_rd_en), ie.act_rd);
          chk("wgt_rd_en", int'(wgt_rd_en), ie.wgt_rd);
          chk("act_addr", int'(act_addr), ie.act_a);
          chk("wgt_addr", int'(wgt_addr), ie.wgt_a);
        end
      end else if (stall_q.size() > 0 && stall_q[0].cyc == cyc) begin
        se = stall_q.pop_front();
        chk("stall_act_addr", int'(act_addr), se.act_a);
        chk("stall_wgt_addr", int'(wgt_addr), se.wgt_a);
      end

      if (pair_valid) begin
        if (pair_q.size() == 0) begin
          chk("spurious_pair", 1, 0);
        end else begin
          pe = pair_q.pop_front();
          chk("pair_cycle", cyc, pe.cyc);
          chk("pair_first", int'(pair_first), pe.first);
          chk("pair_last", int'(pair_last), pe.last);
        end
      end

      if (done) begin
        if (done_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          de = done_q.pop_front();
          chk("done_cycle", cyc, de);
          chk("busy_at_done", int'(busy), 1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // One job: drive start, then a ready pattern, queueing the expected
  // behaviour derived from the loop-nest definition.
  //   pct         : probability (percent) of ready being high each cycle
  //   stall_after : after this many issues, hold ready low for 2 cycles
  //   junk        : also raise start with random fields while busy
  // -------------------------------------------------------------------------
  task automatic run_job(input int a_in, input int w_in, input bit ord,
                         input int pct, input int stall_after, input bit junk);
    int a, w, inner, outer, n, issued, stall_left, t, fcyc;
    int i, o, ai, wi, last_a, last_w;
    bit r;
    a = (a_in > DEPTH) ? DEPTH : a_in;
    w = (w_in > DEPTH) ? DEPTH : w_in;
    inner = ord ? w : a;
    outer = ord ? a : w;
    n = a * w;
    issued = 0;
    stall_left = 2;
    last_a = 0;
    last_w = 0;
    job_no++;
    $display("job %0d: A=%0d W=%0d order=%0d ready%%=%0d pairs=%0d",
             job_no, a_in, w_in, ord, pct, n);

    @(posedge clk); #1;
    t = cyc;
    start = 1'b1;
    order = ord;
    act_nz_count = CNT_W'(a_in);
    weight_nz_count = CNT_W'(w_in);
    ready = 1'($urandom_range(1));

    if (n == 0) begin
      done_q.push_back(t + 1);
      fcyc = t - RD_LAT;
      @(posedge clk); #1;
      start = junk;
      order = 1'($urandom_range(1));
      act_nz_count = CNT_W'($urandom_range(255));
      weight_nz_count = CNT_W'($urandom_range(255));
    end else begin
      fcyc = t;
      while (issued < n) begin
        @(posedge clk); #1;
        start = junk && (issued == 1);
        if (start) begin
          order = 1'($urandom_range(1));
          act_nz_count = CNT_W'($urandom_range(255));
          weight_nz_count = CNT_W'($urandom_range(255));
        end
        if (issued == stall_after && stall_left > 0) begin
          r = 1'b0;
          stall_left--;
        end else begin
          r = ($urandom_range(99) < pct);
        end
        ready = r;
        if (r) begin
          i = issued % inner;
          o = issued / inner;
          ai = ord ? o : i;
          wi = ord ? i : o;
          iss_q.push_back('{cyc, ord ? int'(i == 0) : 1, ord ? 1 : int'(i == 0), ai, wi});
          pair_q.push_back('{cyc + RD_LAT, int'(i == 0), int'(issued == n - 1)});
          last_a = ai;
          last_w = wi;
          issued++;
          if (issued == n) begin
            fcyc = cyc;
            done_q.push_back(cyc + RD_LAT + 1);
          end
        end else begin
          stall_q.push_back('{cyc, last_a, last_w});
        end
      end
    end

    while (cyc < fcyc + RD_LAT + 2) begin
      @(posedge clk); #1;
      start = 1'b0;
      ready = 1'($urandom_range(1));
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    chk("idle_act_addr", int'(act_addr), 0);
    chk("idle_wgt_addr", int'(wgt_addr), 0);
    chk("done_outstanding", done_q.size(), 0);
    chk("reads_outstanding", iss_q.size(), 0);
    chk("pairs_outstanding", pair_q.size(), 0);
    chk("stalls_outstanding", stall_q.size(), 0);
  endtask

  // Reset in the middle of a running job: everything must drop at once and
  // no done pulse may follow.
  task automatic reset_mid_job();
    @(posedge clk); #1;
    mon_en = 1'b0;
    start = 1'b1;
    order = 1'b0;
    act_nz_count = CNT_W'(10);
    weight_nz_count = CNT_W'(10);
    ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ready = 1'b1;
    iss_q.delete();
    pair_q.delete();
    stall_q.delete();
    done_q.delete();
    mon_en = 1'b1;
    $display("job %0d: reset asserted mid-run", job_no);
    @(negedge clk);
    chk("outputs_after_abort",
        int'({act_rd_en, wgt_rd_en, pair_valid, pair_first, pair_last, busy, done, act_addr, wgt_addr}), 0);
    repeat (RD_LAT + 3) begin
      @(negedge clk);
      chk("busy_after_abort", int'(busy), 0);
    end
  endtask

  initial begin
    int a, w, sel;
    reset = 1'b1;
    start = 1'b0;
    order = 1'b0;
    act_nz_count = '0;
    weight_nz_count = '0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        int'({act_rd_en, wgt_rd_en, pair_valid, pair_first, pair_last, busy, done, act_addr, wgt_addr}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    run_job(3, 2, 1'b0, 100, -1, 1'b0);
    run_job(3, 2, 1'b1, 100, -1, 1'b0);
    run_job(4, 1, 1'b0, 100, 2, 1'b0);
    run_job(0, 5, 1'b0, 100, -1, 1'b1);
    run_job(200, 1, 1'b0, 100, -1, 1'b1);
    run_job(5, 0, 1'b1, 100, -1, 1'b0);
    run_job(2, 70, 1'b1, 80, -1, 1'b0);
    reset_mid_job();
    run_job(3, 2, 1'b0, 100, -1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(9);
      if (sel == 0) begin
        a = 0;
        w = $urandom_range(1, 9);
      end else if (sel == 1) begin
        a = $urandom_range(65, 255);
        w = $urandom_range(1, 2);
      end else begin
        a = $urandom_range(1, 10);
        w = $urandom_range(1, 10);
      end
      run_job(a, w, 1'($urandom_range(1)), $urandom_range(40, 100),
              $urandom_range(0, 6), 1'($urandom_range(1)));
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_done_queue", done_q.size(), 0);
    chk("final_read_queue", iss_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
